// File: rtl/nrisc_bus_target.sv
// nrisc_bus_target: bus-side responder for the NRISC-Aurora data bus window.
// Serves a local STATUS register or forwards commands to a peripheral over a
// req/ack handshake bounded by a timeout, then returns a one-cycle BUS_ack.
module nrisc_bus_target #(
  parameter int unsigned TAM     = 16,
  parameter int unsigned N_DData = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DData-1:0] BUS_addr,
  input  logic [TAM-1:0]     BUS_wdata,
  input  logic               BUS_strobe,
  output logic [TAM-1:0]     BUS_rdata,
  output logic               BUS_ack,
  output logic               BUS_busy,
  output logic [N_DData-2:0] PER_addr,
  output logic [TAM-1:0]     PER_wdata,
  output logic               PER_we,
  output logic               PER_req,
  input  logic [TAM-1:0]     PER_rdata,
  input  logic               PER_ack
);

  localparam int unsigned IW = N_DData - 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    err_cnt;
  logic          overrun;
  logic          last_to;
  logic [TAM-1:0] status_word;

  // Assemble the STATUS register view from its individual fields
  always_comb begin
    status_word      = '0;
    status_word[7:2] = err_cnt;
    status_word[1]   = overrun;
    status_word[0]   = last_to;
  end

  // Command FSM with registered bus/peripheral outputs and status bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      err_cnt   <= '0;
      overrun   <= 1'b0;
      last_to   <= 1'b0;
      BUS_rdata <= '0;
      BUS_ack   <= 1'b0;
      BUS_busy  <= 1'b0;
      PER_addr  <= '0;
      PER_wdata <= '0;
      PER_we    <= 1'b0;
      PER_req   <= 1'b0;
    end else begin
      BUS_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (BUS_strobe) begin
            BUS_busy <= 1'b1;
            if (&BUS_addr[IW-1:0]) begin
              // STATUS access completes locally; a write clears all fields
              // on entry to RESP so a following read already sees zero.
              state   <= RESP;
              BUS_ack <= 1'b1;
              if (BUS_addr[N_DData-1]) begin
                err_cnt <= '0;
                overrun <= 1'b0;
                last_to <= 1'b0;
              end else begin
                BUS_rdata <= status_word;
              end
            end else begin
              state     <= REQ;
              cnt       <= '0;
              PER_req   <= 1'b1;
              PER_addr  <= BUS_addr[IW-1:0];
              PER_wdata <= BUS_wdata;
              PER_we    <= BUS_addr[N_DData-1];
            end
          end
        end
        REQ: begin
          if (BUS_strobe) overrun <= 1'b1;
          if (PER_ack) begin
            if (!PER_we) BUS_rdata <= PER_rdata;
            last_to <= 1'b0;
            PER_req <= 1'b0;
            BUS_ack <= 1'b1;
            state   <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            BUS_rdata <= '1;
            last_to   <= 1'b1;
            if (err_cnt != 6'h3F) err_cnt <= err_cnt + 6'd1;
            PER_req   <= 1'b0;
            BUS_ack   <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (BUS_strobe) overrun <= 1'b1;
          BUS_busy <= 1'b0;
          cnt      <= '0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          BUS_busy <= 1'b0;
          PER_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nrisc_bus_target.sv
// tb_nrisc_bus_target: scoreboard bench for nrisc_bus_target with a
// transaction-level reference model and randomized commands.
module tb_nrisc_bus_target;

  localparam int unsigned TAM = 16;
  localparam int unsigned NDD = 8;
  localparam int unsigned TMO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NDD-1:0] BUS_addr = '0;
  logic [TAM-1:0] BUS_wdata = '0;
  logic           BUS_strobe = 1'b0;
  logic [TAM-1:0] BUS_rdata;
  logic           BUS_ack;
  logic           BUS_busy;
  logic [NDD-2:0] PER_addr;
  logic [TAM-1:0] PER_wdata;
  logic           PER_we;
  logic           PER_req;
  logic [TAM-1:0] PER_rdata = '0;
  logic           PER_ack = 1'b0;

  nrisc_bus_target #(.TAM(TAM), .N_DData(NDD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .BUS_addr(BUS_addr), .BUS_wdata(BUS_wdata), .BUS_strobe(BUS_strobe),
    .BUS_rdata(BUS_rdata), .BUS_ack(BUS_ack), .BUS_busy(BUS_busy),
    .PER_addr(PER_addr), .PER_wdata(PER_wdata), .PER_we(PER_we),
    .PER_req(PER_req), .PER_rdata(PER_rdata), .PER_ack(PER_ack)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  typedef struct {
    int unsigned    cyc;
    logic [TAM-1:0] data;
  } exp_t;
  exp_t q[$];

  // Reference model state (transaction level)
  int unsigned    m_err = 0;
  bit             m_ovr = 0;
  bit             m_last = 0;
  logic [TAM-1:0] m_rdata = '0;

  function automatic logic [TAM-1:0] m_status();
    return TAM'(m_err * 4 + (m_ovr ? 2 : 0) + (m_last ? 1 : 0));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every BUS_ack is matched against the oldest expectation
  always @(negedge clk) begin
    if (BUS_ack === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_cycle", cyc, e.cyc);
        chk("bus_rdata", 32'(BUS_rdata), 32'(e.data));
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
    chk("ack_pending", q.size(), 0);
    q.delete();
    @(posedge clk);
  endtask

  // Issue one bus command; d = peripheral ack offset (0 = never acks),
  // ovr = offset of an extra strobe while busy (0 = none), prd = read data.
  task automatic issue(input logic [NDD-1:0] addr, input logic [TAM-1:0] wd,
                       input int unsigned d, input int unsigned ovr,
                       input logic [TAM-1:0] prd);
    bit          is_stat;
    bit          is_wr;
    bit          acked;
    int unsigned lat;
    int unsigned t0;
    exp_t        e;
    is_stat = (addr[NDD-2:0] == {(NDD-1){1'b1}});
    is_wr   = addr[NDD-1];
    acked   = (d >= 1 && d <= TMO);
    @(posedge clk); #1;
    t0 = cyc;
    if (is_stat) begin
      lat = 1;
      if (is_wr) begin
        m_err = 0; m_ovr = 0; m_last = 0;
      end else begin
        m_rdata = m_status();
      end
    end else if (acked) begin
      lat = d + 1;
      m_last = 0;
      if (!is_wr) m_rdata = prd;
    end else begin
      lat = TMO + 1;
      m_last = 1;
      m_rdata = '1;
      if (m_err < 63) m_err++;
    end
    if (ovr != 0) m_ovr = 1;
    e.cyc = t0 + lat;
    e.data = m_rdata;
    q.push_back(e);
    BUS_addr = addr; BUS_wdata = wd; BUS_strobe = 1'b1;
    for (int unsigned k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      BUS_strobe = (k == ovr);
      if (k == ovr) begin
        BUS_addr = NDD'($urandom);
        BUS_wdata = TAM'($urandom);
      end
      PER_ack   = !is_stat && (k == d);
      PER_rdata = (k == d) ? prd : TAM'($urandom);
      if (k == 1) chk("busy", BUS_busy, 1);
      if (!is_stat && k == 1) begin
        chk("per_req_on", PER_req, 1);
        chk("per_addr", 32'(PER_addr), 32'(addr[NDD-2:0]));
        chk("per_we", PER_we, is_wr);
        if (is_wr) chk("per_wdata", 32'(PER_wdata), 32'(wd));
      end
      if (!is_stat && !acked && k == TMO) chk("per_req_last", PER_req, 1);
      if (!is_stat && k == lat) chk("per_req_off", PER_req, 0);
    end
    @(posedge clk); #1;
    BUS_strobe = 1'b0; PER_ack = 1'b0;
    drain();
  endtask

  task automatic model_reset();
    m_err = 0; m_ovr = 0; m_last = 0; m_rdata = '0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", BUS_ack, 0);
    chk("rst_busy", BUS_busy, 0);
    chk("rst_req", PER_req, 0);
    chk("rst_rdata", 32'(BUS_rdata), 0);
    rst = 1'b1;
    model_reset();

    // Status after reset, then directed read/write/timeout
    issue(8'h7F, 16'h0, 0, 0, 16'h0);
    issue(8'h05, 16'h0, 3, 0, 16'hBEEF);
    issue(8'h85, 16'h1234, 1, 0, 16'h5A5A);
    issue(8'h07, 16'h0, 0, 0, 16'h0);
    issue(8'h7F, 16'h0, 0, 0, 16'h0);

    // Overrun during REQ and during a STATUS RESP
    issue(8'h11, 16'h0, 4, 2, 16'hCAFE);
    issue(8'h7F, 16'h0, 0, 0, 16'h0);
    issue(8'hFF, 16'h0, 0, 1, 16'h0);
    issue(8'h7F, 16'h0, 0, 0, 16'h0);
    issue(8'hFF, 16'hAAAA, 0, 0, 16'h0);

    // Saturation of the timeout counter, then clear
    for (int i = 0; i < 70; i++) issue(8'h07, 16'h0, 0, 0, 16'h0);
    issue(8'h7F, 16'h0, 0, 0, 16'h0);
    issue(8'hFF, 16'h0, 0, 0, 16'h0);
    issue(8'h7F, 16'h0, 0, 0, 16'h0);

    // Ack in the final timeout cycle wins
    issue(8'h07, 16'h0, 0, 0, 16'h0);
    issue(8'h22, 16'h0, TMO, 0, 16'h1357);
    issue(8'h7F, 16'h0, 0, 0, 16'h0);

    // Randomized commands
    for (int i = 0; i < 60; i++) begin
      logic [NDD-1:0] a;
      int unsigned    d;
      int unsigned    ov;
      a  = NDD'($urandom);
      if ($urandom_range(0, 5) == 0) a[NDD-2:0] = '1;
      d  = $urandom_range(0, TMO);
      ov = 0;
      if ($urandom_range(0, 3) == 0) begin
        if (a[NDD-2:0] == {(NDD-1){1'b1}}) ov = 1;
        else ov = $urandom_range(1, (d == 0) ? TMO + 1 : d + 1);
      end
      issue(a, TAM'($urandom), d, ov, TAM'($urandom));
    end
    issue(8'h7F, 16'h0, 0, 0, 16'h0);

    // Reset in the middle of a forwarded request
    @(posedge clk); #1;
    BUS_addr = 8'h03; BUS_strobe = 1'b1;
    @(posedge clk); #1;
    BUS_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_req_before", PER_req, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_req", PER_req, 0);
    chk("mid_rst_busy", BUS_busy, 0);
    chk("mid_rst_ack", BUS_ack, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    issue(8'h7F, 16'h0, 0, 0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
